// File: rtl/axi_pkg.sv
// Shared AXI4 widths, encodings and the arbiter's FSM state types.
package axi_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int STRB_W  = 8;
    localparam int ID_W    = 4;
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_XFER,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle. Handshake rule on every channel: a transfer happens in the
// cycle where valid and ready are both 1; the sender holds valid and payload
// stable until then, and ready may depend combinationally on valid.
interface axi_if;
    import axi_pkg::*;

    logic [ID_W-1:0]    awid;
    logic [ADDR_W-1:0]  awaddr;
    logic [LEN_W-1:0]   awlen;
    logic [SIZE_W-1:0]  awsize;
    logic [BURST_W-1:0] awburst;
    logic               awvalid;
    logic               awready;

    logic [DATA_W-1:0]  wdata;
    logic [STRB_W-1:0]  wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;

    logic [ID_W-1:0]    bid;
    logic [RESP_W-1:0]  bresp;
    logic               bvalid;
    logic               bready;

    logic [ID_W-1:0]    arid;
    logic [ADDR_W-1:0]  araddr;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE_W-1:0]  arsize;
    logic [BURST_W-1:0] arburst;
    logic               arvalid;
    logic               arready;

    logic [ID_W-1:0]    rid;
    logic [DATA_W-1:0]  rdata;
    logic [RESP_W-1:0]  rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin selector: on a tie the input that was not served
// last wins; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    // Pick the winner index from the current requests and last winner.
    always_comb begin
        valid = |req;
        grant = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/axi_arbiter.sv
// Two-master to one-slave AXI4 arbiter. Read and write paths each own an
// FSM that locks one master for a whole burst and releases it after the
// final R beat / B response. Grants are registered (one cycle latency);
// forwarding once granted is purely combinational.
module axi_arbiter
    import axi_pkg::*;
(
    input logic   clk,
    input logic   rst,
    axi_if.slave  m0,
    axi_if.slave  m1,
    axi_if.master s
);

    // ---------------- read path ----------------
    rd_state_e rstate, rnext;
    logic      rg;
    logic      rlast_grant;
    logic      r_gnt, r_any;
    logic      sel_arvalid, sel_rready, r_done;

    rr_arb2 u_rd_arb (
        .req   ({m1.arvalid, m0.arvalid}),
        .last  (rlast_grant),
        .grant (r_gnt),
        .valid (r_any)
    );

    assign sel_arvalid = rg ? m1.arvalid : m0.arvalid;
    assign sel_rready  = rg ? m1.rready  : m0.rready;
    assign r_done      = (rstate == R_DATA) && s.rvalid && sel_rready && s.rlast;

    // Read state, grant and round-robin history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate      <= R_IDLE;
            rg          <= 1'b0;
            rlast_grant <= 1'b1;
        end else begin
            rstate <= rnext;
            if (rstate == R_IDLE && r_any) rg <= r_gnt;
            if (r_done) rlast_grant <= rg;
        end
    end

    // Read next-state and AR/R routing for the granted master.
    always_comb begin
        rnext      = rstate;
        s.arid     = '0;
        s.araddr   = '0;
        s.arlen    = '0;
        s.arsize   = '0;
        s.arburst  = '0;
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        m0.arready = 1'b0;
        m0.rid     = '0;
        m0.rdata   = '0;
        m0.rresp   = '0;
        m0.rlast   = 1'b0;
        m0.rvalid  = 1'b0;
        m1.arready = 1'b0;
        m1.rid     = '0;
        m1.rdata   = '0;
        m1.rresp   = '0;
        m1.rlast   = 1'b0;
        m1.rvalid  = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (r_any) rnext = R_ADDR;
            end
            R_ADDR: begin
                s.arid    = rg ? m1.arid    : m0.arid;
                s.araddr  = rg ? m1.araddr  : m0.araddr;
                s.arlen   = rg ? m1.arlen   : m0.arlen;
                s.arsize  = rg ? m1.arsize  : m0.arsize;
                s.arburst = rg ? m1.arburst : m0.arburst;
                s.arvalid = sel_arvalid;
                if (rg) m1.arready = s.arready;
                else    m0.arready = s.arready;
                if (sel_arvalid && s.arready) rnext = R_DATA;
            end
            R_DATA: begin
                s.rready = sel_rready;
                if (rg) begin
                    m1.rid    = s.rid;
                    m1.rdata  = s.rdata;
                    m1.rresp  = s.rresp;
                    m1.rlast  = s.rlast;
                    m1.rvalid = s.rvalid;
                end else begin
                    m0.rid    = s.rid;
                    m0.rdata  = s.rdata;
                    m0.rresp  = s.rresp;
                    m0.rlast  = s.rlast;
                    m0.rvalid = s.rvalid;
                end
                if (r_done) rnext = R_IDLE;
            end
            default: rnext = R_IDLE;
        endcase
    end

    // ---------------- write path ----------------
    wr_state_e wstate, wnext;
    logic      wg;
    logic      wlast_grant;
    logic      aw_done, w_done;
    logic      w_gnt, w_any;
    logic      sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
    logic      aw_fire, w_fire_last, b_fire;

    rr_arb2 u_wr_arb (
        .req   ({m1.awvalid | m1.wvalid, m0.awvalid | m0.wvalid}),
        .last  (wlast_grant),
        .grant (w_gnt),
        .valid (w_any)
    );

    assign sel_awvalid = wg ? m1.awvalid : m0.awvalid;
    assign sel_wvalid  = wg ? m1.wvalid  : m0.wvalid;
    assign sel_wlast   = wg ? m1.wlast   : m0.wlast;
    assign sel_bready  = wg ? m1.bready  : m0.bready;
    // AW and the final W beat may complete in any order, or together.
    assign aw_fire     = (wstate == W_XFER) && sel_awvalid && !aw_done && s.awready;
    assign w_fire_last = (wstate == W_XFER) && sel_wvalid && !w_done && s.wready && sel_wlast;
    assign b_fire      = (wstate == W_RESP) && s.bvalid && sel_bready;

    // Write state, grant, done flags and round-robin history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate      <= W_IDLE;
            wg          <= 1'b0;
            wlast_grant <= 1'b1;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            wstate <= wnext;
            if (wstate == W_IDLE && w_any) begin
                wg      <= w_gnt;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_fire)     aw_done <= 1'b1;
            if (w_fire_last) w_done  <= 1'b1;
            if (b_fire)      wlast_grant <= wg;
        end
    end

    // Write next-state and AW/W/B routing for the granted master.
    always_comb begin
        wnext      = wstate;
        s.awid     = '0;
        s.awaddr   = '0;
        s.awlen    = '0;
        s.awsize   = '0;
        s.awburst  = '0;
        s.awvalid  = 1'b0;
        s.wdata    = '0;
        s.wstrb    = '0;
        s.wlast    = 1'b0;
        s.wvalid   = 1'b0;
        s.bready   = 1'b0;
        m0.awready = 1'b0;
        m0.wready  = 1'b0;
        m0.bid     = '0;
        m0.bresp   = '0;
        m0.bvalid  = 1'b0;
        m1.awready = 1'b0;
        m1.wready  = 1'b0;
        m1.bid     = '0;
        m1.bresp   = '0;
        m1.bvalid  = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (w_any) wnext = W_XFER;
            end
            W_XFER: begin
                s.awid    = wg ? m1.awid    : m0.awid;
                s.awaddr  = wg ? m1.awaddr  : m0.awaddr;
                s.awlen   = wg ? m1.awlen   : m0.awlen;
                s.awsize  = wg ? m1.awsize  : m0.awsize;
                s.awburst = wg ? m1.awburst : m0.awburst;
                s.awvalid = sel_awvalid & ~aw_done;
                s.wdata   = wg ? m1.wdata : m0.wdata;
                s.wstrb   = wg ? m1.wstrb : m0.wstrb;
                s.wlast   = sel_wlast;
                s.wvalid  = sel_wvalid & ~w_done;
                if (wg) begin
                    m1.awready = s.awready & ~aw_done;
                    m1.wready  = s.wready & ~w_done;
                end else begin
                    m0.awready = s.awready & ~aw_done;
                    m0.wready  = s.wready & ~w_done;
                end
                if ((aw_done || aw_fire) && (w_done || w_fire_last)) wnext = W_RESP;
            end
            W_RESP: begin
                s.bready = sel_bready;
                if (wg) begin
                    m1.bid    = s.bid;
                    m1.bresp  = s.bresp;
                    m1.bvalid = s.bvalid;
                end else begin
                    m0.bid    = s.bid;
                    m0.bresp  = s.bresp;
                    m0.bvalid = s.bvalid;
                end
                if (b_fire) wnext = W_IDLE;
            end
            default: wnext = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: a cycle table for the read path plus
// hand-written write, concurrent and reset-mid-burst sequences.
module tb_axi_arbiter;
    import axi_pkg::*;

    localparam logic [31:0] A0      = 32'h8000_0000;
    localparam logic [31:0] A1      = 32'h9000_0040;
    localparam logic [31:0] AW1     = 32'h8000_0100;
    localparam logic [63:0] S_RDATA = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] W_DATA  = 64'h1122_3344_5566_7788;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    axi_if m0_bus ();
    axi_if m1_bus ();
    axi_if s_bus ();

    axi_arbiter dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .s   (s_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs {m0.arvalid, m1.arvalid, s.arready, s.rvalid, s.rlast, rready}
    // expect {s.arvalid, m0.arready, m1.arready, m0.rvalid, m1.rvalid, s.rready}
    typedef struct {
        logic [5:0]  in;
        logic [5:0]  exp;
        logic [31:0] addr;
    } rvec_t;

    rvec_t tbl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [14:0] ctl_bits();
        return {s_bus.arvalid, s_bus.rready, s_bus.awvalid, s_bus.wvalid, s_bus.bready,
                m0_bus.arready, m0_bus.rvalid, m0_bus.awready, m0_bus.wready, m0_bus.bvalid,
                m1_bus.arready, m1_bus.rvalid, m1_bus.awready, m1_bus.wready, m1_bus.bvalid};
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;

        m0_bus.awid = 4'h0; m0_bus.awaddr = '0; m0_bus.awlen = '0; m0_bus.awsize = '0;
        m0_bus.awburst = '0; m0_bus.awvalid = 1'b0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
        m0_bus.wlast = 1'b0; m0_bus.wvalid = 1'b0; m0_bus.bready = 1'b0;
        m0_bus.arid = 4'h1; m0_bus.araddr = A0; m0_bus.arlen = 8'd3; m0_bus.arsize = 3'd3;
        m0_bus.arburst = BURST_INCR; m0_bus.arvalid = 1'b1; m0_bus.rready = 1'b0;

        m1_bus.awid = 4'h3; m1_bus.awaddr = AW1; m1_bus.awlen = '0; m1_bus.awsize = 3'd3;
        m1_bus.awburst = BURST_INCR; m1_bus.awvalid = 1'b0; m1_bus.wdata = W_DATA;
        m1_bus.wstrb = 8'h0F; m1_bus.wlast = 1'b1; m1_bus.wvalid = 1'b0; m1_bus.bready = 1'b0;
        m1_bus.arid = 4'h2; m1_bus.araddr = A1; m1_bus.arlen = 8'd0; m1_bus.arsize = 3'd3;
        m1_bus.arburst = BURST_INCR; m1_bus.arvalid = 1'b0; m1_bus.rready = 1'b0;

        s_bus.awready = 1'b0; s_bus.wready = 1'b0; s_bus.bid = '0; s_bus.bresp = RESP_OKAY;
        s_bus.bvalid = 1'b0; s_bus.arready = 1'b0; s_bus.rid = 4'h1; s_bus.rdata = S_RDATA;
        s_bus.rresp = RESP_OKAY; s_bus.rlast = 1'b0; s_bus.rvalid = 1'b0;

        // ---- reset held 3 cycles with m0 requesting ----
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            chk($sformatf("rst_arvalid%0d", i), {63'd0, s_bus.arvalid}, 64'd0);
        end
        chk("rst_ctl", {49'd0, ctl_bits()}, 64'd0);
        chk("rst_araddr", {32'd0, s_bus.araddr}, 64'd0);
        chk("rst_wdata", s_bus.wdata, 64'd0);

        // ---- read path table: tie, alternation, single 4-beat read ----
        tbl[0]  = '{6'b110001, 6'b000000, 32'h0};
        tbl[1]  = '{6'b111001, 6'b110000, A0};
        tbl[2]  = '{6'b010111, 6'b000101, 32'h0};
        tbl[3]  = '{6'b110001, 6'b000000, 32'h0};
        tbl[4]  = '{6'b111001, 6'b101000, A1};
        tbl[5]  = '{6'b100110, 6'b000010, 32'h0};
        tbl[6]  = '{6'b100111, 6'b000011, 32'h0};
        tbl[7]  = '{6'b100001, 6'b000000, 32'h0};
        tbl[8]  = '{6'b100001, 6'b100000, A0};
        tbl[9]  = '{6'b101001, 6'b110000, A0};
        tbl[10] = '{6'b000101, 6'b000101, 32'h0};
        tbl[11] = '{6'b000001, 6'b000001, 32'h0};
        tbl[12] = '{6'b000101, 6'b000101, 32'h0};
        tbl[13] = '{6'b000101, 6'b000101, 32'h0};
        tbl[14] = '{6'b000111, 6'b000101, 32'h0};
        tbl[15] = '{6'b000101, 6'b000000, 32'h0};

        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m0_bus.arvalid = tbl[i].in[5];
            m1_bus.arvalid = tbl[i].in[4];
            s_bus.arready  = tbl[i].in[3];
            s_bus.rvalid   = tbl[i].in[2];
            s_bus.rlast    = tbl[i].in[1];
            m0_bus.rready  = tbl[i].in[0];
            m1_bus.rready  = tbl[i].in[0];
            sample();
            chk($sformatf("rd_vec%0d", i),
                {58'd0, s_bus.arvalid, m0_bus.arready, m1_bus.arready,
                 m0_bus.rvalid, m1_bus.rvalid, s_bus.rready},
                {58'd0, tbl[i].exp});
            chk($sformatf("rd_addr%0d", i), {32'd0, s_bus.araddr}, {32'd0, tbl[i].addr});
            if (tbl[i].exp[2]) chk($sformatf("rd_m0data%0d", i), m0_bus.rdata, S_RDATA);
            if (tbl[i].exp[1]) chk($sformatf("rd_m1data%0d", i), m1_bus.rdata, S_RDATA);
            next_cycle();
        end
        s_bus.rvalid = 1'b0;
        s_bus.rlast  = 1'b0;

        // ---- write from m1, W two cycles ahead of AW ----
        m1_bus.wvalid = 1'b1;
        sample();
        chk("wr_idle_wvalid", {63'd0, s_bus.wvalid}, 64'd0);
        next_cycle();
        s_bus.wready = 1'b1;
        sample();
        chk("wr_wvalid", {63'd0, s_bus.wvalid}, 64'd1);
        chk("wr_wstrb", {56'd0, s_bus.wstrb}, 64'h0F);
        chk("wr_wdata", s_bus.wdata, W_DATA);
        chk("wr_m1_wready", {62'd0, m1_bus.wready, m0_bus.wready}, 64'b10);
        chk("wr_no_aw_yet", {63'd0, s_bus.awvalid}, 64'd0);
        next_cycle();
        m1_bus.wvalid  = 1'b0;
        s_bus.wready   = 1'b0;
        m1_bus.awvalid = 1'b1;
        sample();
        chk("wr_awvalid", {63'd0, s_bus.awvalid}, 64'd1);
        chk("wr_awaddr", {32'd0, s_bus.awaddr}, {32'd0, AW1});
        chk("wr_m1_awready_lo", {63'd0, m1_bus.awready}, 64'd0);
        next_cycle();
        s_bus.awready = 1'b1;
        sample();
        chk("wr_m1_awready", {63'd0, m1_bus.awready}, 64'd1);
        next_cycle();
        m1_bus.awvalid = 1'b0;
        s_bus.awready  = 1'b0;
        s_bus.bvalid   = 1'b1;
        s_bus.bid      = 4'h3;
        s_bus.bresp    = RESP_OKAY;
        m1_bus.bready  = 1'b1;
        sample();
        chk("wr_b_route", {61'd0, m1_bus.bvalid, m0_bus.bvalid, s_bus.bready}, 64'b101);
        chk("wr_bid", {60'd0, m1_bus.bid}, 64'h3);
        chk("wr_bresp", {62'd0, m1_bus.bresp}, 64'd0);
        next_cycle();
        sample();
        chk("wr_released", {62'd0, m1_bus.bvalid, s_bus.bready}, 64'd0);
        next_cycle();
        s_bus.bvalid  = 1'b0;
        m1_bus.bready = 1'b0;

        // ---- concurrent read m0 + write m1 ----
        m0_bus.arlen   = 8'd0;
        m0_bus.arvalid = 1'b1;
        m1_bus.awvalid = 1'b1;
        m1_bus.wvalid  = 1'b1;
        s_bus.arready  = 1'b1;
        s_bus.awready  = 1'b1;
        s_bus.wready   = 1'b1;
        sample();
        chk("cc_idle", {49'd0, ctl_bits()}, 64'd0);
        next_cycle();
        sample();
        chk("cc_fwd", {57'd0, s_bus.arvalid, s_bus.awvalid, s_bus.wvalid,
                       m0_bus.arready, m1_bus.awready, m1_bus.wready, m0_bus.awready},
            64'b1111110);
        next_cycle();
        m0_bus.arvalid = 1'b0;
        m1_bus.awvalid = 1'b0;
        m1_bus.wvalid  = 1'b0;
        s_bus.arready  = 1'b0;
        s_bus.awready  = 1'b0;
        s_bus.wready   = 1'b0;
        s_bus.rvalid   = 1'b1;
        s_bus.rlast    = 1'b1;
        s_bus.bvalid   = 1'b1;
        m0_bus.rready  = 1'b1;
        m1_bus.rready  = 1'b1;
        m0_bus.bready  = 1'b1;
        m1_bus.bready  = 1'b1;
        sample();
        chk("cc_resp_route", {60'd0, m0_bus.rvalid, m1_bus.rvalid, m1_bus.bvalid, m0_bus.bvalid},
            64'b1010);
        next_cycle();
        sample();
        chk("cc_done", {49'd0, ctl_bits()}, 64'd0);
        next_cycle();
        s_bus.rvalid  = 1'b0;
        s_bus.rlast   = 1'b0;
        s_bus.bvalid  = 1'b0;
        m0_bus.bready = 1'b0;
        m1_bus.bready = 1'b0;

        // ---- reset during beat 2 of a 4-beat m0 read ----
        m0_bus.arlen   = 8'd3;
        m0_bus.arvalid = 1'b1;
        sample();
        chk("rr_idle", {63'd0, s_bus.arvalid}, 64'd0);
        next_cycle();
        s_bus.arready = 1'b1;
        sample();
        chk("rr_ar", {52'd0, s_bus.arvalid, s_bus.arlen, s_bus.arid},
            {52'd0, 1'b1, 8'd3, 4'h1});
        next_cycle();
        m0_bus.arvalid = 1'b0;
        s_bus.arready  = 1'b0;
        s_bus.rvalid   = 1'b1;
        sample();
        chk("rr_beat1", {63'd0, m0_bus.rvalid}, 64'd1);
        next_cycle();
        rst = 1'b1;
        sample();
        chk("rr_beat2", {63'd0, m0_bus.rvalid}, 64'd1);
        next_cycle();
        rst = 1'b0;
        m1_bus.arvalid = 1'b1;
        sample();
        chk("rr_after_rst", {49'd0, ctl_bits()}, 64'd0);
        chk("rr_after_rst_data", m0_bus.rdata, 64'd0);
        next_cycle();
        s_bus.rvalid  = 1'b0;
        s_bus.arready = 1'b1;
        sample();
        chk("rr_m1_ar", {31'd0, s_bus.arvalid, s_bus.araddr}, {31'd0, 1'b1, A1});
        chk("rr_m1_arready", {62'd0, m1_bus.arready, m0_bus.arready}, 64'b10);
        next_cycle();
        m1_bus.arvalid = 1'b0;
        s_bus.arready  = 1'b0;
        s_bus.rvalid   = 1'b1;
        s_bus.rlast    = 1'b1;
        sample();
        chk("rr_m1_r", {62'd0, m1_bus.rvalid, m0_bus.rvalid}, 64'b10);
        next_cycle();
        sample();
        chk("rr_m1_released", {49'd0, ctl_bits()}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
